instr_encoder: RTL

- Encode direction for the core's immediate datapath: packs opcode, register fields and a 64-bit sign-extended immediate into a 32-bit RV64 instruction word.
- Immediate bit placement is the exact inverse of Imm_Gen decoding.
- Sits between the test/boot loader and instruction memory.
- Two-stage valid/ready pipeline with range checking, a sequential write-address counter and a saturating error counter.

---
 rtl/instr_encoder_pkg.sv | 19 +
 rtl/instr_encoder_pack.sv | 52 +++++
 rtl/instr_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV64 instruction encoder: format selectors,
// the canonical NOP word and the immediate range helper.
package instr_encoder_pkg;

  localparam logic [2:0]  FMT_R     = 3'b011;
  localparam logic [2:0]  FMT_I0    = 3'b000;
  localparam logic [2:0]  FMT_I1    = 3'b001;
  localparam logic [2:0]  FMT_S     = 3'b010;
  localparam logic [2:0]  FMT_SB    = 3'b110;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [7:0]  ERR_MAX   = 8'hFF;

  // A 12-bit signed immediate fits when bits [63:11] are a pure sign extension.
  function automatic logic imm_fits12(input logic signed [63:0] imm);
    return (&imm[63:11]) | ~(|imm[63:11]);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: places opcode, register fields and the immediate into
// a 32-bit word, the inverse of the Imm_Gen decode, and flags range/format errors.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [2:0]         funct3,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [6:0]         funct7,
  input  logic signed [63:0] imm,
  output logic [31:0]        instr,
  output logic               err
);

  logic [2:0] w_fmt;
  logic       w_fits;

  assign w_fmt  = opcode[6:4];
  assign w_fits = imm_fits12(imm);

  // Out-of-range immediates still pack their low 12 bits; only err reports it.
  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (w_fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I0, FMT_I1: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = ~w_fits;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = ~w_fits;
      end
      FMT_SB: begin
        // imm is in halfword units, so imm[11] is the branch sign and imm[10] lands in bit 7.
        instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        err   = ~w_fits;
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder between the boot loader and
// instruction memory, with a sequential write-address counter and error count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

  logic              r_s1_valid;
  logic [6:0]        r_s1_opcode;
  logic [4:0]        r_s1_rd;
  logic [2:0]        r_s1_funct3;
  logic [4:0]        r_s1_rs1;
  logic [4:0]        r_s1_rs2;
  logic [6:0]        r_s1_funct7;
  logic signed [63:0] r_s1_imm;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic              r_out_err;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [7:0]        r_err_count;

  logic              w_s2_adv;
  logic              w_s1_to_s2;
  logic              w_accept;
  logic              w_out_hs;
  logic [31:0]       w_instr;
  logic              w_err;

  assign w_s2_adv   = ~r_out_valid | out_ready;
  assign w_s1_to_s2 = r_s1_valid & w_s2_adv;
  assign in_ready   = ~r_s1_valid | w_s2_adv;
  assign w_accept   = in_valid & in_ready;
  assign w_out_hs   = r_out_valid & out_ready;

  // Stage 1: capture the field bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_opcode <= opcode;
      r_s1_rd     <= rd;
      r_s1_funct3 <= funct3;
      r_s1_rs1    <= rs1;
      r_s1_rs2    <= rs2;
      r_s1_funct7 <= funct7;
      r_s1_imm    <= imm;
    end
  end

  instr_pack u_pack (
    .opcode (r_s1_opcode),
    .rd     (r_s1_rd),
    .funct3 (r_s1_funct3),
    .rs1    (r_s1_rs1),
    .rs2    (r_s1_rs2),
    .funct7 (r_s1_funct7),
    .imm    (r_s1_imm),
    .instr  (w_instr),
    .err    (w_err)
  );

  // Stage 2: packed word, error flag and write address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= 1'b0;
      r_out_addr  <= BASE_ADDR;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_instr <= w_instr;
        r_out_err   <= w_err;
        r_out_addr  <= r_addr_cnt;
      end
    end
  end

  // A load wins over the advance; the entry moving this edge already took the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_cnt <= BASE_ADDR;
    end else if (addr_load) begin
      r_addr_cnt <= addr_value;
    end else if (w_s1_to_s2) begin
      r_addr_cnt <= r_addr_cnt + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_out_hs && r_out_err) begin
      r_err_count <= sat_inc(r_err_count);
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign out_addr  = r_out_addr;
  assign err_count = r_err_count;

endmodule
